sym_fir_mac: RTL and testbench

//  Downstream consumer of the BRAM symmetric shift register: takes the mirrored tap pairs
//  (x[n-k], x[n-(N-1-k)]) one pair per beat, pre-adds them, multiplies by a run-time writable

---
 rtl/sym_fir_mac.sv | 157 +++++++++++++++
 tb/tb_sym_fir_mac.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sym_fir_mac.sv
// Purpose: symmetric FIR back end; pre-adds mirrored tap pairs, multiplies by a RAM coefficient,
//          accumulates one frame per output sample, then rounds and saturates the result.
// Latency: beat with s_last accepted in cycle T -> m_valid high in cycle T+3 when not stalled.
// Backpressure: s_ready = ~m_valid | m_ready; the whole pipeline freezes while a result waits.
// Optional build macro: SYM_FIR_ANTISYM_EN adds port antisym (per-beat pre-subtract).
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   s_tap_a/s_tap_b/s_center/s_last    tap pair beat, centre-tap flag, end of frame
//   s_valid/s_ready                    input handshake
//   coef_we/coef_addr/coef_wdata       coefficient RAM write port (always accepted)
//   m_data/m_valid/m_ready             result handshake, result held until accepted
//   busy                               frame in progress until its result is loaded
//   ovf/ovf_clr                        sticky saturation/overrun flag and its clear
module sym_fir_mac #(
  parameter int DW        = 16,
  parameter int CW        = 18,
  parameter int AW        = 6,
  parameter int OW        = 16,
  parameter int OUT_SHIFT = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_tap_a,
  input  logic [DW-1:0] s_tap_b,
  input  logic          s_center,
  input  logic          s_last,
  input  logic          s_valid,
  output logic          s_ready,
`ifdef SYM_FIR_ANTISYM_EN
  input  logic          antisym,
`endif
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic [OW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          busy,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int PW  = DW + 1;   // pre-adder width
  localparam int MW  = PW + CW;  // product width
  localparam int ACW = MW + AW;  // accumulator width, headroom for 2**AW products

  localparam logic [AW-1:0]         IDX_MAX = '1;
  localparam logic signed [ACW:0]   RND     = (ACW+1)'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACW:0]   MAXV    = (ACW+1)'((2**(OW-1)) - 1);
  localparam logic signed [ACW:0]   MINV    = ~MAXV;

  logic en, accept;
  assign en      = ~m_valid | m_ready;
  assign s_ready = en;
  assign accept  = s_valid & en;

  // Coefficient RAM: no reset, writes independent of the pipeline enable.
  logic [CW-1:0] coef_mem [2**AW];
  always_ff @(posedge clk) begin
    if (coef_we) coef_mem[coef_addr] <= coef_wdata;
  end

  // Stage 1 pre-adder; the centre tap has no partner so b is forced to zero.
  logic signed [PW-1:0] a_ext, b_ext, pre_d;
  always_comb begin
    a_ext = {s_tap_a[DW-1], s_tap_a};
    b_ext = s_center ? '0 : {s_tap_b[DW-1], s_tap_b};
`ifdef SYM_FIR_ANTISYM_EN
    pre_d = antisym ? (a_ext - b_ext) : (a_ext + b_ext);
`else
    pre_d = a_ext + b_ext;
`endif
  end

  logic [AW-1:0]         idx;
  logic                  in_frame;
  logic                  v1, last1, first1;
  logic signed [PW-1:0]  pre1;
  logic signed [CW-1:0]  coef1;
  logic                  v2, last2, first2;
  logic signed [MW-1:0]  prod2;
  logic signed [ACW-1:0] acc;

  // Stage 3 combinational: first beat loads rather than adds, so no clear cycle between frames.
  logic signed [ACW-1:0] prod_ext, acc_next;
  logic signed [ACW:0]   rnd, shifted;
  logic [OW-1:0]         res;
  logic                  sat_hit;
  always_comb begin
    prod_ext = {{AW{prod2[MW-1]}}, prod2};
    acc_next = first2 ? prod_ext : (acc + prod_ext);
    rnd      = {acc_next[ACW-1], acc_next} + RND;
    shifted  = rnd >>> OUT_SHIFT;
    sat_hit  = 1'b0;
    res      = OW'(shifted);
    if (shifted > MAXV) begin
      res     = OW'(MAXV);
      sat_hit = 1'b1;
    end else if (shifted < MINV) begin
      res     = OW'(MINV);
      sat_hit = 1'b1;
    end
  end

  logic overrun, ovf_set;
  assign overrun = accept & ~s_last & (idx == IDX_MAX);
  assign ovf_set = overrun | (en & v2 & last2 & sat_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      in_frame <= 1'b0;
      v1       <= 1'b0;
      last1    <= 1'b0;
      first1   <= 1'b0;
      pre1     <= '0;
      coef1    <= '0;
      v2       <= 1'b0;
      last2    <= 1'b0;
      first2   <= 1'b0;
      prod2    <= '0;
      acc      <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      busy     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (en) begin
        // Stage 1: capture beat and read coefficient for the current tap index.
        v1 <= accept;
        if (accept) begin
          pre1     <= pre_d;
          coef1    <= coef_mem[idx];
          last1    <= s_last;
          first1   <= ~in_frame;
          in_frame <= ~s_last;
          if (s_last)            idx <= '0;
          else if (idx != IDX_MAX) idx <= idx + AW'(1);
        end
        // Stage 2: multiply.
        v2     <= v1;
        last2  <= last1;
        first2 <= first1;
        prod2  <= MW'(pre1) * MW'(coef1);
        // Stage 3: accumulate, and on the last beat load the output register.
        if (v2) acc <= acc_next;
        if (v2 & last2) m_data <= res;
        m_valid <= v2 & last2;
        // Busy while the frame is open or any of its beats are still ahead of stage 3.
        busy <= (accept ? ~s_last : in_frame) | accept | v1;
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sym_fir_mac.sv
module tb_sym_fir_mac;
  localparam int DW = 16;
  localparam int CW = 18;
  localparam int AW = 3;
  localparam int OW = 16;
  localparam int SH = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tap_a, s_tap_b;
  logic          s_center, s_last, s_valid, s_ready;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic [OW-1:0] m_data;
  logic          m_valid, m_ready, busy, ovf, ovf_clr;

  always #5 clk = ~clk;

  sym_fir_mac #(.DW(DW), .CW(CW), .AW(AW), .OW(OW), .OUT_SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tap_a(s_tap_a), .s_tap_b(s_tap_b), .s_center(s_center), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  longint sb[$];
  int pc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  longint exp_v;
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %0d expected none", $signed(m_data));
      end else begin
        exp_v = sb.pop_front();
        chk("result", longint'($signed(m_data)), exp_v);
        pc.push_back(cyc);
      end
    end
  end

  // All tasks start and end at #1 after a rising edge.
  task automatic wcoef(input int addr, input longint val);
    coef_we    = 1'b1;
    coef_addr  = AW'(addr);
    coef_wdata = CW'(val);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic beat(input longint a, input longint b, input bit ctr, input bit lst);
    int n;
    s_tap_a  = DW'(a);
    s_tap_b  = DW'(b);
    s_center = ctr;
    s_last   = lst;
    s_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got s_ready=0 expected 1");
    end
    @(posedge clk); #1;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_center = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) begin
      tests++;
      fails++;
      $display("FAIL result_timeout: got m_valid=0 expected 1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_tap_a = '0; s_tap_b = '0; s_center = 1'b0; s_last = 1'b0;
    s_valid = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    m_ready = 1'b1; ovf_clr = 1'b0;
    @(negedge clk);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Four equal pairs, coefficients 1..4: (2+4+6+8+1)>>1 = 10, latency 3.
    for (int i = 0; i < 4; i++) wcoef(i, i + 1);
    sb.push_back(10);
    beat(1, 1, 0, 0);
    chk("busy_in_frame", busy, 1);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 1);
    @(negedge clk); chk("lat_cycle1", m_valid, 0);
    @(negedge clk); chk("lat_cycle2", m_valid, 0);
    @(negedge clk); chk("lat_cycle3", m_valid, 1);
    chk("busy_done", busy, 0);
    drain();

    // Odd frame with centre tap (b ignored): acc=128 -> (128+1)>>1 = 64.
    wcoef(0, 8); wcoef(1, 8); wcoef(2, 16);
    sb.push_back(64);
    beat(2, 2, 0, 0);
    beat(2, 2, 0, 0);
    beat(4, 99, 1, 1);
    drain();

    // Positive saturation, sticky flag, clear.
    wcoef(0, 131071);
    sb.push_back(32767);
    beat(32767, 32767, 0, 1);
    wait_res();
    chk("ovf_pos_sat", ovf, 1);
    drain();
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // Negative saturation; leave ovf set.
    sb.push_back(-32768);
    beat(-32768, -32768, 0, 1);
    wait_res();
    chk("ovf_neg_sat", ovf, 1);
    drain();

    // Arithmetic shift of a negative sum: (-3+1)>>>1 = -1.
    wcoef(0, 1);
    sb.push_back(-1);
    beat(-3, 0, 0, 1);
    drain();

    // Backpressure: result held, input stalled, no beat lost.
    m_ready = 1'b0;
    sb.push_back(6);
    beat(5, 6, 0, 1);
    wait_res();
    @(posedge clk); #1;
    sb.push_back(4);
    fork
      beat(7, 0, 0, 1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_s_ready", s_ready, 0);
          chk("bp_m_data", m_data, 6);
          chk("bp_m_valid", m_valid, 1);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Back-to-back single-beat frames: one result per cycle, in order.
    pc.delete();
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(i);
      beat(2 * i, 0, 0, 1);
    end
    drain();
    chk("b2b_count", pc.size(), 5);
    if (pc.size() == 5) chk("b2b_spacing", pc[4] - pc[0], 4);

    // Reset mid-frame discards it; next frame starts at coef[0].
    for (int i = 0; i < 4; i++) wcoef(i, i + 1);
    chk("ovf_sticky", ovf, 1);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.push_back(3);
    beat(1, 1, 0, 0);
    beat(1, 1, 0, 1);
    drain();

    // Full-depth frame (8 beats) is legal; a 9th beat holds idx at max and flags ovf.
    for (int i = 0; i < 7; i++) wcoef(i, 1);
    wcoef(7, 3);
    sb.push_back(10);
    for (int i = 0; i < 8; i++) beat(1, 1, 0, i == 7);
    drain();
    chk("full_depth_no_ovf", ovf, 0);
    sb.push_back(13);
    for (int i = 0; i < 9; i++) begin
      beat(1, 1, 0, i == 8);
      if (i == 7) chk("overrun_ovf", ovf, 1);
    end
    drain();
    chk("overrun_ovf_sticky", ovf, 1);

    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
